debug_host: RTL

DEBUG_HOST -- requirements
Module: debug_host

---
 rtl/debug_host.sv | 129 ++++++++++++
 1 files changed

// File: rtl/debug_host.sv
// Command/dump host: sends one command byte to a UART transmitter and, when the
// command expects an answer, reassembles a FRAME_BYTES-byte response frame.
// Optional response watchdog is enabled with macro DEBUG_HOST_TIMEOUT_EN.
module debug_host #(
  parameter int FRAME_BYTES    = 172,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     top_clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_code,
  input  logic                     cmd_expect,
  output logic                     cmd_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_bus,
  input  logic                     tx_done_tick,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_bus,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, COLLECT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             expect_q;
  logic             accept;
  logic             store;

`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer;
  logic             timeout_hit;
`endif

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    tx_start    = 1'b0;
    frame_valid = 1'b0;
    accept      = 1'b0;
    store       = 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_tick) state_nxt = expect_q ? COLLECT : IDLE;
      end
      COLLECT: begin
        if (rx_done_tick) begin
          store = 1'b1;
          if (cnt == CNT_LAST) state_nxt = DONE;
        end
`ifdef DEBUG_HOST_TIMEOUT_EN
        else if (timer == TMR_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
`endif
      end
      DONE: begin
        frame_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_bus doubles as the latched command code, so it stays stable until tx_done_tick
  always_ff @(posedge top_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      expect_q   <= 1'b0;
      tx_bus     <= '0;
      frame_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_bus   <= cmd_code;
        expect_q <= cmd_expect;
        cnt      <= '0;
      end
      if (store) begin
        cnt <= cnt + 1'b1;
        for (int k = 0; k < FRAME_BYTES; k++) begin
          if (cnt == CNT_W'(k)) frame_data[8*k +: 8] <= rx_bus;
        end
      end
    end
  end

`ifdef DEBUG_HOST_TIMEOUT_EN
  // Timer is held at zero outside COLLECT, which also restarts it on entry
  always_ff @(posedge top_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != COLLECT || store) timer <= '0;
      else                           timer <= timer + 1'b1;
      if (accept)           timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
